// File: rtl/spi_reg_ctrl.sv
// SPI-to-register-file bridge: a command byte selects read/write and a start
// address, then each following byte is one auto-incrementing register access.
module spi_reg_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ssel,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       frame_err,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WRITE    = 3'd2,
        RD_FETCH = 3'd3,
        RD_CAPT  = 3'd4,
        READ     = 3'd5
    } state_t;

    state_t state, state_next;

    logic ssel_meta, ssel_sync, cs_act;
    logic cmd_take, wr_take, rd_advance, ferr_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ssel_meta <= 1'b1;
            ssel_sync <= 1'b1;
        end else begin
            ssel_meta <= ssel;
            ssel_sync <= ssel_meta;
        end
    end

    assign cs_act    = ~ssel_sync;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Handshake: rx_valid is a single-cycle qualifier with no back-pressure; a
    // byte is consumed only when rx_valid=1 and cs_act=1 in a state that wants
    // it. reg_we/reg_re are one-cycle strobes with no ready; reg_rdata is
    // taken exactly one clk after reg_re.
    always_comb begin
        state_next = state;
        reg_re     = 1'b0;
        cmd_take   = 1'b0;
        wr_take    = 1'b0;
        rd_advance = 1'b0;
        ferr_next  = 1'b0;
        if (!cs_act) begin
            state_next = IDLE;
            ferr_next  = (state == CMD);
        end else begin
            case (state)
                IDLE: state_next = CMD;
                CMD: begin
                    if (rx_valid) begin
                        cmd_take   = 1'b1;
                        state_next = rx_data[7] ? RD_FETCH : WRITE;
                    end
                end
                WRITE: wr_take = rx_valid;
                RD_FETCH: begin
                    reg_re     = rst;
                    state_next = RD_CAPT;
                end
                RD_CAPT: state_next = READ;
                READ: begin
                    if (rx_valid) begin
                        rd_advance = 1'b1;
                        state_next = RD_FETCH;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tx_data   <= SYNC_BYTE;
            reg_addr  <= 7'd0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            reg_we    <= wr_take;
            frame_err <= ferr_next;
            if (wr_take) begin
                reg_wdata <= rx_data;
            end
            // Write bursts advance the cycle after the strobe so reg_we sees
            // the address the byte belongs to; 7-bit rollover gives the wrap.
            if (cmd_take) begin
                reg_addr <= rx_data[6:0];
            end else if (rd_advance || reg_we) begin
                reg_addr <= reg_addr + 7'd1;
            end
            if (state_next == IDLE) begin
                tx_data <= SYNC_BYTE;
            end else if (state == RD_CAPT) begin
                tx_data <= reg_rdata;
            end
        end
    end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter: SYNC_BYTE, 8'hA5, byte presented on tx_data while the command byte is shifted.
REQ-002 Port: clk  in  1  system clock, rising-edge; clk frequency SHALL be at least 8x SCK.
REQ-003 Port: rst  in  1  reset, synchronous, active-low.
REQ-004 Port: ssel  in  1  raw SPI chip select, active-low, asynchronous to clk.
REQ-005 Port: rx_valid  in  1  one-cycle pulse, received byte available from the SPI slave.
REQ-006 Port: rx_data  in  8  received byte, valid when rx_valid=1.
REQ-007 Port: tx_data  out  8  byte the SPI slave loads for the next transfer.
REQ-008 Port: reg_addr  out  7  register-file address.
REQ-009 Port: reg_wdata  out  8  register write data.
REQ-010 Port: reg_we  out  1  one-cycle write strobe.
REQ-011 Port: reg_re  out  1  one-cycle read strobe.
REQ-012 Port: reg_rdata  in  8  read data, valid exactly one clk after reg_re.
REQ-013 Port: busy  out  1  high while a frame is active (state != IDLE).
REQ-014 Port: frame_err  out  1  one-cycle pulse, frame ended before any command byte was received.

Function
REQ-015 ssel SHALL pass through a 2-flop synchronizer; cs_act = ~ssel_sync; all decisions use cs_act only.
REQ-016 States: IDLE, CMD, WRITE, RD_FETCH, RD_CAPT, READ.
REQ-017 IDLE -> CMD when cs_act=1; tx_data SHALL equal SYNC_BYTE in IDLE and CMD.
REQ-018 CMD, rx_valid: rx_data[7]=1 -> RD_FETCH, rx_data[7]=0 -> WRITE; reg_addr <= rx_data[6:0] in both cases.
REQ-019 WRITE, rx_valid: reg_wdata <= rx_data and reg_we=1 for exactly one cycle at current reg_addr; reg_addr increments the following cycle.
REQ-020 RD_FETCH: reg_re=1 for one cycle at reg_addr -> RD_CAPT.
REQ-021 RD_CAPT: tx_data <= reg_rdata -> READ; rdata-to-tx_data latency SHALL be 1 clk after reg_re; total cmd-byte-to-tx_data valid latency SHALL be 3 clk.
REQ-022 READ, rx_valid (end of data byte): reg_addr increments; rx_data ignored; -> RD_FETCH (prefetch next byte).
REQ-023 reg_addr SHALL wrap 7'h7F -> 7'h00 in both read and write bursts.
REQ-024 Any state, cs_act=0 -> IDLE next cycle; cs_act=0 SHALL take priority over simultaneous rx_valid (no reg_we, no reg_re issued that cycle).
REQ-025 frame_err SHALL pulse one cycle when cs_act falls while in CMD; no pulse from any other state.
REQ-026 reg_we and reg_re SHALL never be high in the same cycle; neither SHALL be high in IDLE or CMD.
REQ-027 rx_valid in RD_FETCH or RD_CAPT SHALL be ignored (cannot occur when REQ-002 holds).
REQ-028 tx_data SHALL hold its value except at the updates in REQ-017 and REQ-021.

Reset
REQ-029 rst=0 at a clk edge: state=IDLE, tx_data=SYNC_BYTE, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, frame_err=0, busy=0, synchronizer flops=1 (inactive).
REQ-030 Reset mid-frame SHALL abort without any further strobe; after release a new frame requires cs_act to be observed low-to-high (ssel high-to-low) again, or cs_act=1 while in IDLE.

Verification
REQ-031 Write burst: ssel low, bytes 0x10,0x11,0x22,0x33 -> reg_we pulses at addr 0x10/0x11/0x12 with data 0x11/0x22/0x33; tx for first byte = 0xA5.
REQ-032 Read burst: ssel low, cmd 0x90, 2 dummy bytes, regfile[0x10]=0xDE,[0x11]=0xAD -> MISO bytes 0xA5,0xDE,0xAD; reg_re at 0x10,0x11,0x12.
REQ-033 Wrap: write cmd 0x7F, data 0x01,0x02 -> writes at 0x7F then 0x00.
REQ-034 Empty frame: ssel low 20 clk then high, no SCK -> frame_err one pulse, no strobes, busy back to 0.
REQ-035 Abort: ssel rises in same cycle as rx_valid in WRITE -> no reg_we, state IDLE next cycle.
REQ-036 Reset during READ: rst low 1 clk -> all outputs at REQ-029 values next cycle, no reg_re afterward while ssel stays high.
